// File: rtl/pipeline_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_unit
// Purpose  : RV32I control path. Decodes in D, carries control through E/M/W,
//            and resolves branches and jumps in E.
// Options  : CTRL_UNSIGNED_BRANCH_EN enables bltu/bgeu decode and resolution.
// Revision : 1.0
// ============================================================================
module pipeline_ctrl_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [6:0]      op_code,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            FLUSH_E,
    input  logic [XLEN-1:0] SRC_A_E,
    input  logic [XLEN-1:0] SRC_B_E,
    output logic [2:0]      ImmSrcD,
    output logic            ILLEGAL_D,
    output logic [3:0]      ALU_controlE,
    output logic            ALU_SRCE,
    output logic            Result_SRCE0,
    output logic            reg_writeE,
    output logic            reg_writeM,
    output logic            reg_writeW,
    output logic            mem_writeM,
    output logic [1:0]      Result_SRCW,
    output logic            PCSrcE,
    output logic            PC_TGT_SRCE
);

    localparam logic [6:0] c_OP_LW     = 7'b0000011;
    localparam logic [6:0] c_OP_SW     = 7'b0100011;
    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_BR     = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;

    localparam logic [2:0] c_IMM_I     = 3'b000;
    localparam logic [2:0] c_IMM_S     = 3'b001;
    localparam logic [2:0] c_IMM_B     = 3'b010;
    localparam logic [2:0] c_IMM_J     = 3'b011;
    localparam logic [2:0] c_IMM_U     = 3'b100;

    localparam logic [3:0] c_ALU_ADD   = 4'b0000;
    localparam logic [3:0] c_ALU_SUB   = 4'b0001;
    localparam logic [3:0] c_ALU_AND   = 4'b0010;
    localparam logic [3:0] c_ALU_OR    = 4'b0011;
    localparam logic [3:0] c_ALU_XOR   = 4'b0100;
    localparam logic [3:0] c_ALU_SLT   = 4'b0101;
    localparam logic [3:0] c_ALU_SLTU  = 4'b0110;
    localparam logic [3:0] c_ALU_SLL   = 4'b0111;
    localparam logic [3:0] c_ALU_SRL   = 4'b1000;
    localparam logic [3:0] c_ALU_SRA   = 4'b1001;

    localparam logic [1:0] c_RES_ALU   = 2'b00;
    localparam logic [1:0] c_RES_MEM   = 2'b01;
    localparam logic [1:0] c_RES_PC4   = 2'b10;
    localparam logic [1:0] c_RES_IMM   = 2'b11;

    // D-stage decode
    logic       w_alt;
    logic [3:0] w_alu_funct;
    logic [3:0] w_alu_ctrl;
    logic [2:0] w_imm_src;
    logic [1:0] w_result_src;
    logic       w_illegal;
    logic       w_reg_write;
    logic       w_mem_write;
    logic       w_alu_src;
    logic       w_branch;
    logic       w_jump;
    logic       w_jalr;

    // E/M/W pipeline registers
    logic       r_reg_write_e;
    logic       r_mem_write_e;
    logic [1:0] r_result_src_e;
    logic [3:0] r_alu_ctrl_e;
    logic       r_alu_src_e;
    logic       r_branch_e;
    logic       r_jump_e;
    logic       r_jalr_e;
    logic [2:0] r_funct3_e;
    logic       r_reg_write_m;
    logic       r_mem_write_m;
    logic [1:0] r_result_src_m;
    logic       r_reg_write_w;
    logic [1:0] r_result_src_w;

    // E-stage branch resolution
    logic       w_eq;
    logic       w_lt;
    logic       w_cond_raw;
    logic       w_cond;

    // funct7b5 selects sub/sra for R-type; for I-type only srai uses it
    assign w_alt = funct7b5 & ((op_code == c_OP_R) | (funct3 == 3'b101));

    always_comb begin
        w_alu_funct = c_ALU_ADD;
        case (funct3)
            3'b000:  w_alu_funct = w_alt ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  w_alu_funct = c_ALU_SLL;
            3'b010:  w_alu_funct = c_ALU_SLT;
            3'b011:  w_alu_funct = c_ALU_SLTU;
            3'b100:  w_alu_funct = c_ALU_XOR;
            3'b101:  w_alu_funct = w_alt ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  w_alu_funct = c_ALU_OR;
            default: w_alu_funct = c_ALU_AND;
        endcase
    end

    always_comb begin
        w_imm_src    = c_IMM_I;
        w_result_src = c_RES_ALU;
        w_alu_ctrl   = c_ALU_ADD;
        w_illegal    = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_alu_src    = 1'b0;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
        w_jalr       = 1'b0;
        case (op_code)
            c_OP_LW: begin
                w_reg_write  = 1'b1;
                w_result_src = c_RES_MEM;
                w_alu_src    = 1'b1;
            end
            c_OP_SW: begin
                w_imm_src    = c_IMM_S;
                w_mem_write  = 1'b1;
                w_alu_src    = 1'b1;
            end
            c_OP_R: begin
                w_reg_write  = 1'b1;
                w_alu_ctrl   = w_alu_funct;
                w_illegal    = funct7b5 & (funct3 != 3'b000) & (funct3 != 3'b101);
            end
            c_OP_I: begin
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_alu_ctrl   = w_alu_funct;
            end
            c_OP_BR: begin
                w_imm_src    = c_IMM_B;
                w_branch     = 1'b1;
                w_alu_ctrl   = c_ALU_SUB;
`ifdef CTRL_UNSIGNED_BRANCH_EN
                w_illegal    = (funct3[2:1] == 2'b01);
`else
                w_illegal    = (funct3[2:1] == 2'b01) | (funct3[2:1] == 2'b11);
`endif
            end
            c_OP_JAL: begin
                w_imm_src    = c_IMM_J;
                w_reg_write  = 1'b1;
                w_result_src = c_RES_PC4;
                w_jump       = 1'b1;
            end
            c_OP_JALR: begin
                w_reg_write  = 1'b1;
                w_result_src = c_RES_PC4;
                w_alu_src    = 1'b1;
                w_jump       = 1'b1;
                w_jalr       = 1'b1;
            end
            c_OP_LUI: begin
                w_imm_src    = c_IMM_U;
                w_reg_write  = 1'b1;
                w_result_src = c_RES_IMM;
                w_alu_src    = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign ImmSrcD   = w_imm_src;
    assign ILLEGAL_D = w_illegal;

    // Illegal encodings enter E with every side-effecting enable cleared
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_reg_write_e  <= 1'b0;
            r_mem_write_e  <= 1'b0;
            r_result_src_e <= 2'b00;
            r_alu_ctrl_e   <= 4'b0000;
            r_alu_src_e    <= 1'b0;
            r_branch_e     <= 1'b0;
            r_jump_e       <= 1'b0;
            r_jalr_e       <= 1'b0;
            r_funct3_e     <= 3'b000;
        end else if (FLUSH_E) begin
            r_reg_write_e  <= 1'b0;
            r_mem_write_e  <= 1'b0;
            r_result_src_e <= 2'b00;
            r_alu_ctrl_e   <= 4'b0000;
            r_alu_src_e    <= 1'b0;
            r_branch_e     <= 1'b0;
            r_jump_e       <= 1'b0;
            r_jalr_e       <= 1'b0;
            r_funct3_e     <= 3'b000;
        end else begin
            r_reg_write_e  <= w_reg_write & ~w_illegal;
            r_mem_write_e  <= w_mem_write & ~w_illegal;
            r_result_src_e <= w_result_src;
            r_alu_ctrl_e   <= w_alu_ctrl;
            r_alu_src_e    <= w_alu_src;
            r_branch_e     <= w_branch & ~w_illegal;
            r_jump_e       <= w_jump & ~w_illegal;
            r_jalr_e       <= w_jalr & ~w_illegal;
            r_funct3_e     <= funct3;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_reg_write_m  <= 1'b0;
            r_mem_write_m  <= 1'b0;
            r_result_src_m <= 2'b00;
            r_reg_write_w  <= 1'b0;
            r_result_src_w <= 2'b00;
        end else begin
            r_reg_write_m  <= r_reg_write_e;
            r_mem_write_m  <= r_mem_write_e;
            r_result_src_m <= r_result_src_e;
            r_reg_write_w  <= r_reg_write_m;
            r_result_src_w <= r_result_src_m;
        end
    end

    assign w_eq = (SRC_A_E == SRC_B_E);
    assign w_lt = ($signed(SRC_A_E) < $signed(SRC_B_E));

`ifdef CTRL_UNSIGNED_BRANCH_EN
    logic w_ltu;
    assign w_ltu = (SRC_A_E < SRC_B_E);
`endif

    // funct3[2:1] picks the comparison, funct3[0] negates it
    always_comb begin
        w_cond_raw = 1'b0;
        case (r_funct3_e[2:1])
            2'b00:   w_cond_raw = w_eq;
            2'b10:   w_cond_raw = w_lt;
`ifdef CTRL_UNSIGNED_BRANCH_EN
            2'b11:   w_cond_raw = w_ltu;
`endif
            default: w_cond_raw = 1'b0;
        endcase
    end

    assign w_cond = w_cond_raw ^ r_funct3_e[0];

    assign ALU_controlE = r_alu_ctrl_e;
    assign ALU_SRCE     = r_alu_src_e;
    assign Result_SRCE0 = r_result_src_e[0];
    assign reg_writeE   = r_reg_write_e;
    assign reg_writeM   = r_reg_write_m;
    assign reg_writeW   = r_reg_write_w;
    assign mem_writeM   = r_mem_write_m;
    assign Result_SRCW  = r_result_src_w;
    assign PCSrcE       = (r_branch_e & w_cond) | r_jump_e;
    assign PC_TGT_SRCE  = r_jalr_e;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl_unit
// Purpose  : Scoreboard bench for pipeline_ctrl_unit with directed vectors.
// Revision : 1.0
// ============================================================================
module tb_pipeline_ctrl_unit;

    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_BR   = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;
    localparam logic [6:0] c_OP_JALR = 7'b1100111;
    localparam logic [6:0] c_OP_LUI  = 7'b0110111;
    localparam logic [6:0] c_OP_FNC  = 7'b0001111;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [6:0]  op_code = 7'b0;
    logic [2:0]  funct3 = 3'b0;
    logic        funct7b5 = 1'b0;
    logic        FLUSH_E = 1'b0;
    logic [31:0] SRC_A_E = 32'b0;
    logic [31:0] SRC_B_E = 32'b0;
    logic [2:0]  ImmSrcD;
    logic        ILLEGAL_D;
    logic [3:0]  ALU_controlE;
    logic        ALU_SRCE;
    logic        Result_SRCE0;
    logic        reg_writeE;
    logic        reg_writeM;
    logic        reg_writeW;
    logic        mem_writeM;
    logic [1:0]  Result_SRCW;
    logic        PCSrcE;
    logic        PC_TGT_SRCE;

    pipeline_ctrl_unit #(.XLEN(32)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .op_code      (op_code),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .FLUSH_E      (FLUSH_E),
        .SRC_A_E      (SRC_A_E),
        .SRC_B_E      (SRC_B_E),
        .ImmSrcD      (ImmSrcD),
        .ILLEGAL_D    (ILLEGAL_D),
        .ALU_controlE (ALU_controlE),
        .ALU_SRCE     (ALU_SRCE),
        .Result_SRCE0 (Result_SRCE0),
        .reg_writeE   (reg_writeE),
        .reg_writeM   (reg_writeM),
        .reg_writeW   (reg_writeW),
        .mem_writeM   (mem_writeM),
        .Result_SRCW  (Result_SRCW),
        .PCSrcE       (PCSrcE),
        .PC_TGT_SRCE  (PC_TGT_SRCE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int cyc;
        int id;
        int val;
    } exp_t;

    exp_t        sb[$];
    exp_t        sb_keep[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] pa = 32'b0;
    logic [31:0] pb = 32'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int sig_val(input int id);
        case (id)
            0:       return int'(ILLEGAL_D);
            1:       return int'(ImmSrcD);
            2:       return int'(reg_writeE);
            3:       return int'(ALU_controlE);
            4:       return int'(ALU_SRCE);
            5:       return int'(Result_SRCE0);
            6:       return int'(PCSrcE);
            7:       return int'(PC_TGT_SRCE);
            8:       return int'(reg_writeM);
            9:       return int'(mem_writeM);
            10:      return int'(reg_writeW);
            default: return int'(Result_SRCW);
        endcase
    endfunction

    function automatic string sig_name(input int id);
        case (id)
            0:       return "ILLEGAL_D";
            1:       return "ImmSrcD";
            2:       return "reg_writeE";
            3:       return "ALU_controlE";
            4:       return "ALU_SRCE";
            5:       return "Result_SRCE0";
            6:       return "PCSrcE";
            7:       return "PC_TGT_SRCE";
            8:       return "reg_writeM";
            9:       return "mem_writeM";
            10:      return "reg_writeW";
            default: return "Result_SRCW";
        endcase
    endfunction

    // Monitor: compares every expectation due in the current cycle
    always @(negedge CLK) begin
        sb_keep.delete();
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc) begin
                n_checks = n_checks + 1;
                if (sig_val(sb[i].id) == sb[i].val)
                    n_pass = n_pass + 1;
                else
                    $display("FAIL %s cyc=%0d got=%0h expected=%0h",
                             sig_name(sb[i].id), cyc, sig_val(sb[i].id), sb[i].val);
            end else begin
                sb_keep.push_back(sb[i]);
            end
        end
        sb = sb_keep;
    end

    task automatic push(input int c, input int id, input int v);
        exp_t e;
        if (v >= 0) begin
            e.cyc = c;
            e.id  = id;
            e.val = v;
            sb.push_back(e);
        end
    endtask

    // Drives one instruction into D; a/b are the operands it sees once in E.
    // A value of -1 marks an expectation as unspecified.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b, input logic flush,
                         input int ill, input int imm, input int rw, input int mw,
                         input int rs, input int alu, input int asrc,
                         input int pcs, input int tgt);
        int c;
        c = cyc;
        SRC_A_E  = pa;
        SRC_B_E  = pb;
        pa       = a;
        pb       = b;
        op_code  = op;
        funct3   = f3;
        funct7b5 = f7;
        FLUSH_E  = flush;
        push(c, 0, ill);
        push(c, 1, imm);
        if (flush) begin
            rw = 0; mw = 0; rs = 0; alu = 0; asrc = 0; pcs = 0; tgt = 0;
        end
        push(c + 1, 2, rw);
        push(c + 1, 3, alu);
        push(c + 1, 4, asrc);
        push(c + 1, 5, (rs < 0) ? -1 : (rs & 1));
        push(c + 1, 6, pcs);
        push(c + 1, 7, tgt);
        push(c + 2, 8, rw);
        push(c + 2, 9, mw);
        push(c + 3, 10, rw);
        push(c + 3, 11, rs);
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_mid();
        sb.delete();
        RST = 1'b1;
        for (int id = 2; id < 12; id++) push(cyc, id, 0);
        push(cyc, 0, 0);
        push(cyc, 1, 0);
        #1;
        n_checks = n_checks + 1;
        if (PCSrcE === 1'b0)
            n_pass = n_pass + 1;
        else
            $display("FAIL async reset PCSrcE=%b", PCSrcE);
        n_checks = n_checks + 1;
        if (PC_TGT_SRCE === 1'b0)
            n_pass = n_pass + 1;
        else
            $display("FAIL async reset PC_TGT_SRCE=%b", PC_TGT_SRCE);
        n_checks = n_checks + 1;
        if (reg_writeE === 1'b0)
            n_pass = n_pass + 1;
        else
            $display("FAIL async reset reg_writeE=%b", reg_writeE);
        n_checks = n_checks + 1;
        if ({reg_writeM, reg_writeW, mem_writeM} === 3'b000)
            n_pass = n_pass + 1;
        else
            $display("FAIL async reset M/W enables=%b%b%b", reg_writeM, reg_writeW, mem_writeM);
        n_checks = n_checks + 1;
        if ({Result_SRCW, ALU_controlE} === 6'b000000)
            n_pass = n_pass + 1;
        else
            $display("FAIL async reset Result_SRCW=%b ALU_controlE=%b", Result_SRCW, ALU_controlE);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        @(posedge CLK);
        #1;
        for (int id = 2; id < 12; id++) push(cyc, id, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        //    op         f3    f7  a             b             fl  ill imm rw mw rs  alu asrc pcs tgt
        issue(c_OP_R,    3'd0, 1'b0, 32'd0,        32'd0,        1'b0, 0, -1, 1, 0, 0,  0,  0,  0,  0);
        issue(c_OP_R,    3'd0, 1'b1, 32'd0,        32'd0,        1'b0, 0, -1, 1, 0, 0,  1,  0,  0,  0);
        issue(c_OP_SW,   3'd2, 1'b0, 32'd0,        32'd0,        1'b1, 0,  1, 0, 1, -1, 0,  1,  0,  0);
        issue(c_OP_SW,   3'd2, 1'b0, 32'd0,        32'd0,        1'b0, 0,  1, 0, 1, -1, 0,  1,  0,  0);
        issue(c_OP_LW,   3'd2, 1'b0, 32'd0,        32'd0,        1'b0, 0,  0, 1, 0, 1,  0,  1,  0,  0);
        issue(c_OP_I,    3'd0, 1'b1, 32'd0,        32'd0,        1'b0, 0,  0, 1, 0, 0,  0,  1,  0,  0);
        issue(c_OP_I,    3'd5, 1'b1, 32'd0,        32'd0,        1'b0, 0,  0, 1, 0, 0,  9,  1,  0,  0);
        issue(c_OP_I,    3'd5, 1'b0, 32'd0,        32'd0,        1'b0, 0,  0, 1, 0, 0,  8,  1,  0,  0);
        issue(c_OP_I,    3'd1, 1'b1, 32'd0,        32'd0,        1'b0, 0,  0, 1, 0, 0,  7,  1,  0,  0);
        issue(c_OP_R,    3'd3, 1'b0, 32'd0,        32'd0,        1'b0, 0, -1, 1, 0, 0,  6,  0,  0,  0);
        issue(c_OP_I,    3'd4, 1'b0, 32'd0,        32'd0,        1'b0, 0,  0, 1, 0, 0,  4,  1,  0,  0);
        issue(c_OP_R,    3'd6, 1'b0, 32'd0,        32'd0,        1'b0, 0, -1, 1, 0, 0,  3,  0,  0,  0);
        issue(c_OP_R,    3'd7, 1'b0, 32'd0,        32'd0,        1'b0, 0, -1, 1, 0, 0,  2,  0,  0,  0);
        issue(c_OP_I,    3'd2, 1'b0, 32'd0,        32'd0,        1'b0, 0,  0, 1, 0, 0,  5,  1,  0,  0);
        issue(c_OP_R,    3'd5, 1'b1, 32'd0,        32'd0,        1'b0, 0, -1, 1, 0, 0,  9,  0,  0,  0);
        issue(c_OP_R,    3'd1, 1'b0, 32'd0,        32'd0,        1'b0, 0, -1, 1, 0, 0,  7,  0,  0,  0);
        // Signed and equality branches
        issue(c_OP_BR,   3'd4, 1'b0, 32'hFFFFFFFF, 32'd1,        1'b0, 0,  2, 0, 0, -1, 1,  0,  1,  0);
        issue(c_OP_BR,   3'd4, 1'b0, 32'd1,        32'hFFFFFFFF, 1'b0, 0,  2, 0, 0, -1, 1,  0,  0,  0);
        issue(c_OP_BR,   3'd5, 1'b0, 32'd5,        32'd5,        1'b0, 0,  2, 0, 0, -1, 1,  0,  1,  0);
        issue(c_OP_BR,   3'd0, 1'b0, 32'd7,        32'd7,        1'b0, 0,  2, 0, 0, -1, 1,  0,  1,  0);
        issue(c_OP_BR,   3'd1, 1'b0, 32'd7,        32'd7,        1'b0, 0,  2, 0, 0, -1, 1,  0,  0,  0);
        issue(c_OP_BR,   3'd1, 1'b0, 32'd7,        32'd8,        1'b0, 0,  2, 0, 0, -1, 1,  0,  1,  0);
        // Flush coinciding with the taken bne above
        issue(c_OP_R,    3'd0, 1'b0, 32'd0,        32'd0,        1'b1, 0, -1, 1, 0, 0,  0,  0,  0,  0);
`ifdef CTRL_UNSIGNED_BRANCH_EN
        issue(c_OP_BR,   3'd6, 1'b0, 32'hFFFFFFFF, 32'd1,        1'b0, 0,  2, 0, 0, -1, 1,  0,  0,  0);
        issue(c_OP_BR,   3'd6, 1'b0, 32'd0,        32'd1,        1'b0, 0,  2, 0, 0, -1, 1,  0,  1,  0);
        issue(c_OP_BR,   3'd7, 1'b0, 32'd1,        32'hFFFFFFFF, 1'b0, 0,  2, 0, 0, -1, 1,  0,  0,  0);
        issue(c_OP_BR,   3'd7, 1'b0, 32'hFFFFFFFF, 32'd1,        1'b0, 0,  2, 0, 0, -1, 1,  0,  1,  0);
`else
        issue(c_OP_BR,   3'd6, 1'b0, 32'd0,        32'd1,        1'b0, 1, -1, 0, 0, -1, -1, -1, 0, -1);
        issue(c_OP_BR,   3'd7, 1'b0, 32'd5,        32'd5,        1'b0, 1, -1, 0, 0, -1, -1, -1, 0, -1);
`endif
        // Jumps and lui
        issue(c_OP_JALR, 3'd0, 1'b0, 32'd0,        32'd0,        1'b0, 0,  0, 1, 0, 2,  0,  1,  1,  1);
        issue(c_OP_JAL,  3'd0, 1'b0, 32'd0,        32'd0,        1'b0, 0,  3, 1, 0, 2, -1, -1,  1,  0);
        issue(c_OP_LUI,  3'd0, 1'b0, 32'd0,        32'd0,        1'b0, 0,  4, 1, 0, 3, -1, -1,  0,  0);
        // Illegal encodings
        issue(c_OP_FNC,  3'd0, 1'b0, 32'd0,        32'd0,        1'b0, 1, -1, 0, 0, -1, -1, -1, 0, -1);
        issue(c_OP_R,    3'd1, 1'b1, 32'd0,        32'd0,        1'b0, 1, -1, 0, 0, -1, -1, -1, 0, -1);
        issue(c_OP_BR,   3'd2, 1'b0, 32'd3,        32'd3,        1'b0, 1, -1, 0, 0, -1, -1, -1, 0, -1);
        // Reset with lw in E and sw in M
        issue(c_OP_SW,   3'd2, 1'b0, 32'd0,        32'd0,        1'b0, 0,  1, 0, 1, -1, 0,  1,  0,  0);
        issue(c_OP_LW,   3'd2, 1'b0, 32'd0,        32'd0,        1'b0, 0,  0, 1, 0, 1,  0,  1,  0,  0);
        reset_mid();
        issue(c_OP_LW,   3'd2, 1'b0, 32'd0,        32'd0,        1'b0, 0,  0, 1, 0, 1,  0,  1,  0,  0);
        for (int i = 0; i < 4; i++)
            issue(c_OP_I, 3'd0, 1'b0, 32'd0,       32'd0,        1'b0, 0,  0, 1, 0, 0,  0,  1,  0,  0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
        #1;
        foreach (sb[i]) begin
            n_checks = n_checks + 1;
            $display("FAIL %s never checked (due cyc=%0d expected=%0h)",
                     sig_name(sb[i].id), sb[i].cyc, sb[i].val);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
